// File: rtl/im_arbiter_pkg.sv
// im_arbiter_pkg: shared sizes and run-control state encoding for im_arbiter
package im_arbiter_pkg;
    localparam int NUM_C_DEF  = 4;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/im_arbiter_rr_arbiter.sv
// im_arbiter_rr_arbiter: combinational round-robin pick starting at ptr_i
// elig_i: eligible requesters, ptr_i: search start
// gnt_o: one-hot winner (0 if none), idx_o: winner index
module im_arbiter_rr_arbiter #(
    parameter int NUM_C = 4,
    parameter int IDX_W = 2
) (
    input  logic [NUM_C-1:0] elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NUM_C-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);
    always_comb begin
        int j;
        logic [IDX_W-1:0] jj;
        gnt_o = '0;
        idx_o = '0;
        // Walk from the farthest offset down so the lane nearest ptr_i is the last (winning) write.
        for (int k = NUM_C - 1; k >= 0; k--) begin
            j  = (int'(ptr_i) + k) % NUM_C;
            jj = j[IDX_W-1:0];
            if (elig_i[jj]) begin
                gnt_o = NUM_C'(1) << jj;
                idx_o = jj;
            end
        end
    end
endmodule

// File: rtl/im_arbiter.sv
// im_arbiter: round-robin sharing of one instruction-memory read port among NUM_C cores
// clk/rst: clock, sync active-high reset; start: run pulse; core_done: per-core ENDOP level
// req/addr: per-lane fetch requests; gnt/rvalid/data_out: per-lane grant, response pulse, word
// mem_en/mem_addr/mem_rdata: memory port (data one cycle after mem_en); running/all_done: run status
module im_arbiter
    import im_arbiter_pkg::*;
#(
    parameter int NUM_C  = NUM_C_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_C-1:0]        core_done,
    input  logic [NUM_C-1:0]        req,
    input  logic [NUM_C*ADDR_W-1:0] addr,
    output logic [NUM_C-1:0]        gnt,
    output logic [NUM_C-1:0]        rvalid,
    output logic [NUM_C*DATA_W-1:0] data_out,
    output logic                    mem_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    running,
    output logic                    all_done
);
    localparam int IDX_W = (NUM_C > 1) ? $clog2(NUM_C) : 1;
    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_q, rr_d, win, pend_id_q;
    logic                    pend_valid_q;
    logic [NUM_C-1:0]        elig, rvalid_q;
    logic [NUM_C*DATA_W-1:0] data_q;
    assign elig = (state_q == RUN) ? (req & ~core_done) : '0;
    im_arbiter_rr_arbiter #(.NUM_C(NUM_C), .IDX_W(IDX_W)) u_rr (
        .elig_i (elig),
        .ptr_i  (rr_q),
        .gnt_o  (gnt),
        .idx_o  (win)
    );
    assign mem_en   = |gnt;
    assign mem_addr = mem_en ? addr[win*ADDR_W +: ADDR_W] : '0;
    assign rvalid   = rvalid_q;
    assign data_out = data_q;
    assign running  = (state_q == RUN);
    assign all_done = (state_q == DONE);
    always_comb begin
        state_d = (state_q == IDLE && start)        ? RUN  :
                  (state_q == RUN && (&core_done))  ? DONE :
                  (state_q == DONE && start)        ? IDLE : state_q;
        // A fresh run always starts its search at lane 0.
        rr_d    = (state_q == IDLE && start) ? '0 :
                  !mem_en                    ? rr_q :
                  (win == IDX_W'(NUM_C - 1)) ? '0 : win + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
            rvalid_q     <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            pend_valid_q <= mem_en;
            pend_id_q    <= win;
            rvalid_q     <= '0;
            // Responses drain regardless of run state; only new grants are gated.
            if (pend_valid_q) begin
                rvalid_q[pend_id_q]                  <= 1'b1;
                data_q[pend_id_q*DATA_W +: DATA_W]   <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_im_arbiter.sv
// tb_im_arbiter: directed stimulus with a per-cycle reference model and literal spot checks
module tb_im_arbiter;
    logic        clk = 1'b0;
    logic        rst, start, mem_en, running, all_done;
    logic [3:0]  core_done, req, gnt, rvalid;
    logic [63:0] addr, data_out;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    int checks = 0;
    int errors = 0;
    int          m_state = 0, m_ptr = 0, m_pend_id = 0, m_rv = -1;
    bit          m_pend_v = 0, m_init = 0;
    logic [15:0] m_pend_a = '0;
    logic [15:0] m_data [4];
    logic [3:0]  g [5];

    always #5 clk = ~clk;

    im_arbiter dut (
        .clk(clk), .rst(rst), .start(start), .core_done(core_done), .req(req), .addr(addr),
        .gnt(gnt), .rvalid(rvalid), .data_out(data_out), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .running(running), .all_done(all_done)
    );

    // Memory returns its own address, one cycle after the read.
    always @(posedge clk) mem_rdata <= mem_en ? mem_addr : 16'hDEAD;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        int w;
        logic [63:0] ed;
        w = -1;
        if (m_state == 1)
            for (int k = 0; k < 4; k++)
                if (w < 0 && req[(m_ptr + k) % 4] && !core_done[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        if (m_init) begin
            ed = '0;
            for (int i = 0; i < 4; i++) ed[i*16 +: 16] = m_data[i];
            chk("m_gnt", gnt, (w < 0) ? 64'd0 : (64'd1 << w));
            chk("m_mem_en", mem_en, w >= 0);
            chk("m_mem_addr", mem_addr, (w < 0) ? 64'd0 : 64'(addr[w*16 +: 16]));
            chk("m_rvalid", rvalid, (m_rv < 0) ? 64'd0 : (64'd1 << m_rv));
            chk("m_data_out", data_out, ed);
            chk("m_running", running, m_state == 1);
            chk("m_all_done", all_done, m_state == 2);
        end
        if (rst) begin
            m_state = 0; m_ptr = 0; m_pend_v = 0; m_rv = -1; m_init = 1;
            for (int i = 0; i < 4; i++) m_data[i] = '0;
        end else begin
            m_rv = m_pend_v ? m_pend_id : -1;
            if (m_pend_v) m_data[m_pend_id] = m_pend_a;
            m_pend_v = (w >= 0);
            if (w >= 0) begin
                m_pend_id = w;
                m_pend_a  = addr[w*16 +: 16];
                m_ptr     = (w + 1) % 4;
            end
            if (m_state == 0 && start) begin
                m_state = 1;
                m_ptr   = 0;
            end else if (m_state == 1 && core_done == 4'hF) m_state = 2;
            else if (m_state == 2 && start) m_state = 0;
        end
    end

    initial begin
        rst = 1; start = 0; core_done = 0; req = 0; addr = '0;
        step(); step();
        rst = 0;
        #2;
        chk("rst_running", running, 0);
        chk("rst_all_done", all_done, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_data", data_out, 0);
        // single requester, core 2 at address 5
        step(); start = 1;
        step(); start = 0; req = 4'b0100; addr[32 +: 16] = 16'd5;
        #2;
        chk("t1_gnt", gnt, 4'b0100);
        chk("t1_mem_addr", mem_addr, 16'd5);
        step(); req = 0;
        step();
        #2;
        chk("t1_rvalid", rvalid, 4'b0100);
        chk("t1_data2", data_out[32 +: 16], 16'd5);
        // all cores, after steering rr_ptr to 0 with one core-3 grant
        step(); req = 4'b1000; addr = {16'h13, 16'h12, 16'h11, 16'h10};
        step(); req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #2;
            g[i] = gnt;
            step();
        end
        req = 0;
        chk("t2_g0", g[0], 4'b0001);
        chk("t2_g1", g[1], 4'b0010);
        chk("t2_g2", g[2], 4'b0100);
        chk("t2_g3", g[3], 4'b1000);
        chk("t2_g4", g[4], 4'b0001);
        step(); step();
        // cores 1 and 3 with rr_ptr at 2; start in RUN is ignored
        req = 4'b0010; start = 1;
        step(); start = 0; req = 4'b1010;
        #2;
        chk("t3_first", gnt, 4'b1000);
        chk("t3_run_kept", running, 1);
        step(); req = 4'b0010;
        #2;
        chk("t3_second", gnt, 4'b0010);
        step(); req = 4'b0101;
        #2;
        chk("t3_ptr_at_2", gnt, 4'b0100);
        step(); req = 0;
        step(); step();
        // all cores done while core 0 read is in flight
        req = 4'b0001; addr[0 +: 16] = 16'h40;
        #2;
        chk("t4_gnt", gnt, 4'b0001);
        step(); req = 0; core_done = 4'hF;
        #2;
        chk("t4_still_run", running, 1);
        step();
        #2;
        chk("t4_rvalid", rvalid, 4'b0001);
        chk("t4_data0", data_out[0 +: 16], 16'h40);
        chk("t4_running", running, 0);
        chk("t4_all_done", all_done, 1);
        req = 4'hF;
        #1;
        chk("t4_no_gnt", gnt, 0);
        // restart from DONE: start -> IDLE, start -> RUN with rr_ptr 0
        step(); req = 0; start = 1;
        step(); start = 0; core_done = 0;
        #2;
        chk("t6_idle_run", running, 0);
        chk("t6_idle_done", all_done, 0);
        step(); start = 1;
        step(); start = 0; req = 4'hF;
        #2;
        chk("t6_running", running, 1);
        chk("t6_gnt", gnt, 4'b0001);
        // reset right after a grant to core 1
        step(); req = 4'b0010; addr[16 +: 16] = 16'h77;
        #2;
        chk("t5_gnt", gnt, 4'b0010);
        step(); req = 0; rst = 1;
        step(); rst = 0;
        #2;
        chk("t5_rvalid", rvalid, 0);
        chk("t5_data1", data_out[16 +: 16], 16'h0);
        chk("t5_running", running, 0);
        step();
        #2;
        chk("t5_rvalid_later", rvalid, 0);
        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
